// File: rtl/seven_seg_rx.sv
// Receiver for a time-multiplexed seven-segment bus: debounces each digit over
// repeated scans and recovers its hex value, blank state and invalid-pattern errors.
module seven_seg_rx #(
   parameter int DIGITS = 4,
   parameter int STABLE = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stb,
   input  logic [6:0]            seg,
   input  logic [DIGITS-1:0]     dig,
   output logic [4*DIGITS-1:0]   hex,
   output logic [DIGITS-1:0]     blank,
   output logic                  upd,
   output logic [2:0]            upd_idx,
   output logic                  err
);

   localparam logic [3:0]        STABLE_C = 4'(STABLE);
   localparam logic [DIGITS-1:0] ONE_C    = DIGITS'(1);

   // Returns {valid, isBlank, value[3:0]} for a pattern in abcdefg order.
   function automatic logic [5:0] decodeSeg(input logic [6:0] s);
      case (s)
         7'h7E:   decodeSeg = 6'b10_0000;
         7'h30:   decodeSeg = 6'b10_0001;
         7'h6D:   decodeSeg = 6'b10_0010;
         7'h79:   decodeSeg = 6'b10_0011;
         7'h33:   decodeSeg = 6'b10_0100;
         7'h5B:   decodeSeg = 6'b10_0101;
         7'h5F:   decodeSeg = 6'b10_0110;
         7'h70:   decodeSeg = 6'b10_0111;
         7'h7F:   decodeSeg = 6'b10_1000;
         7'h7B:   decodeSeg = 6'b10_1001;
         7'h77:   decodeSeg = 6'b10_1010;
         7'h1F:   decodeSeg = 6'b10_1011;
         7'h4E:   decodeSeg = 6'b10_1100;
         7'h3D:   decodeSeg = 6'b10_1101;
         7'h4F:   decodeSeg = 6'b10_1110;
         7'h47:   decodeSeg = 6'b10_1111;
         7'h00:   decodeSeg = 6'b01_0000;
         default: decodeSeg = 6'b00_0000;
      endcase
   endfunction

   logic [6:0]          cand_q [DIGITS];
   logic [6:0]          cand_d [DIGITS];
   logic [3:0]          cnt_q  [DIGITS];
   logic [3:0]          cnt_d  [DIGITS];
   logic [4*DIGITS-1:0] hex_q, hex_d;
   logic [DIGITS-1:0]   blank_q, blank_d;
   logic                upd_q, upd_d;
   logic [2:0]          updIdx_q, updIdx_d;
   logic                err_q, err_d;

   logic                oneHot;
   logic                restart;
   logic [3:0]          newCnt;
   logic [5:0]          dec;

   assign oneHot = (dig != '0) && ((dig & (dig - ONE_C)) == '0);

   always_comb begin
      cand_d   = cand_q;
      cnt_d    = cnt_q;
      hex_d    = hex_q;
      blank_d  = blank_q;
      upd_d    = 1'b0;
      updIdx_d = updIdx_q;
      err_d    = 1'b0;
      restart  = 1'b0;
      newCnt   = 4'd0;
      dec      = 6'd0;

      if (stb && !oneHot) begin
         err_d = 1'b1;
      end

      // A restart on a changed pattern is always eligible for acceptance, so
      // STABLE=1 accepts every new pattern even though the old count was saturated.
      for (int i = 0; i < DIGITS; i++) begin
         if (stb && oneHot && dig[i]) begin
            restart = (seg != cand_q[i]);
            if (restart) begin
               newCnt = 4'd1;
            end else if (cnt_q[i] == STABLE_C) begin
               newCnt = STABLE_C;
            end else begin
               newCnt = cnt_q[i] + 4'd1;
            end
            cand_d[i] = seg;
            cnt_d[i]  = newCnt;

            if ((newCnt == STABLE_C) && (restart || (cnt_q[i] != STABLE_C))) begin
               dec = decodeSeg(seg);
               if (dec[5]) begin
                  if ((hex_q[4*i +: 4] != dec[3:0]) || blank_q[i]) begin
                     upd_d    = 1'b1;
                     updIdx_d = 3'(i);
                  end
                  hex_d[4*i +: 4] = dec[3:0];
                  blank_d[i]      = 1'b0;
               end else if (dec[4]) begin
                  if (!blank_q[i]) begin
                     upd_d    = 1'b1;
                     updIdx_d = 3'(i);
                  end
                  blank_d[i] = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            cand_q[i] <= 7'd0;
            cnt_q[i]  <= 4'd0;
         end
         hex_q    <= '0;
         blank_q  <= '1;
         upd_q    <= 1'b0;
         updIdx_q <= 3'd0;
         err_q    <= 1'b0;
      end else begin
         cand_q   <= cand_d;
         cnt_q    <= cnt_d;
         hex_q    <= hex_d;
         blank_q  <= blank_d;
         upd_q    <= upd_d;
         updIdx_q <= updIdx_d;
         err_q    <= err_d;
      end
   end

   assign hex     = hex_q;
   assign blank   = blank_q;
   assign upd     = upd_q;
   assign upd_idx = updIdx_q;
   assign err     = err_q;

endmodule

// File: doc/seven_seg_rx.md
Name: seven_seg_rx

Overview:
- Receiving end of the hex-to-7-segment path. Samples a time-multiplexed segment bus (segments plus one-hot digit strobe) and recovers the 4-bit hex value of each digit.
- Each digit is debounced over repeated scans, and unrecognised patterns are flagged.
- Used as a display-bus monitor and loopback checker for the segment drivers, and to read external scanned displays into the fabric.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE, 3, consecutive identical scans of a digit required before it is accepted (1..15).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- stb  in  1  sample qualifier; seg and dig are valid in this cycle.
- seg  in  7  segment pattern {a,b,c,d,e,f,g}, bit 6 = a; 1 = lit.
- dig  in  DIGITS  one-hot digit select; bit i = digit i.
- hex  out  4*DIGITS  accepted value; digit i in hex[4i+3:4i].
- blank  out  DIGITS  bit i = 1 when digit i's accepted pattern is all-off.
- upd  out  1  one-cycle pulse: an accepted digit changed.
- upd_idx  out  3  index of the digit reported by upd.
- err  out  1  one-cycle pulse: stable invalid pattern, or stb with non-one-hot dig.

Behaviour:
- Decode table (seg hex, abcdefg order):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
  - 00 = blank
  - any other value = invalid.
- Reset (rst_n low, asynchronous):
  - hex=0, blank=all 1, upd=0, upd_idx=0, err=0.
  - Every digit tracker is cleared: cand=0, cnt=0.
  - Reset mid-scan discards all partial counts.
- Cycles with stb=0: no state change; upd and err return to 0.
- Cycles with stb=1: dig must be one-hot. If it is zero or has more than one bit set:
  - err pulses the next cycle.
  - No tracker changes.
- Per-digit tracker i, when stb=1 and dig selects digit i:
  - seg == cand[i]: cnt[i] increments, saturating at STABLE.
  - seg != cand[i]: cand[i] <= seg and cnt[i] <= 1 (restart).
  - Acceptance event: new cnt == STABLE and old cnt != STABLE. Fires exactly once per stable run. With STABLE=1, it fires on every change of pattern.
- On an acceptance event:
  - Valid hex pattern: hex[i] <= decoded value, blank[i] <= 0.
  - 00: blank[i] <= 1; hex[i] is held.
  - Invalid pattern: hex[i] and blank[i] are held; err pulses.
  - upd pulses with upd_idx=i only when hex[i] or blank[i] actually changes value. Re-accepting an identical value gives no upd.
- Latency: all outputs are registered. upd and err assert in the cycle after the qualifying stb, and hex/blank are updated in that same cycle.
- Only one digit is processed per cycle, so upd and err can never collide across digits.
- Trackers of non-selected digits hold their state. Scan order is unconstrained.
- cnt width is 4 bits. DIGITS ≤ 8 keeps upd_idx at 3 bits; unused upper bits are 0.

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle -> hex=0000, blank=F, upd=0, err=0 immediately. After release, two scans of digit 0 with seg=30 give no upd (STABLE=3).
- Acceptance: three stb on dig=0001 with seg=5B -> in the cycle after the third: hex[3:0]=5, blank[0]=0, upd=1, upd_idx=0. A fourth identical scan -> no upd.
- Debounce restart: digit 2 scanned with 7F, 7F, 77, 77, 77 -> no update after the 7Fs; hex[11:8]=A with upd, upd_idx=2 after the fifth scan.
- Interleaved scan: round-robin dig 0001→0010→0100→1000 with patterns 7E, 47, 4F, 1F, three rounds -> hex=B E F 0 (hex=16'hBEF0), four upd pulses at idx 0,1,2,3.
- Invalid/blank: digit 1 stable on 01 -> err pulses once, hex[7:4] unchanged. Then stable on 00 -> blank[1]=1, upd, upd_idx=1.
- Bad strobe: stb with dig=0000, then with dig=0011 -> err pulse each time; trackers unchanged (a following stable 30 on digit 0 still needs exactly 3 scans).
